// File: rtl/minimal_mem_responder_if.sv
// Request/response bundle between the accelerator's minimal memory port and its responder.
// MINIMAL_MEM_RESPONDER_ERR_EN adds the M_err response flag.
interface minimal_mem_responder_if #(
  parameter int BITSIZE_addr = 32,
  parameter int BITSIZE_data = 32,
  parameter int BITSIZE_size = 6
);
  logic                    Mout_oe_ram;
  logic                    Mout_we_ram;
  logic [BITSIZE_addr-1:0] Mout_addr_ram;
  logic [BITSIZE_size-1:0] Mout_data_ram_size;
  logic [BITSIZE_data-1:0] Mout_Wdata_ram;
  logic [BITSIZE_data-1:0] M_Rdata_ram;
  logic                    M_DataRdy;
`ifdef MINIMAL_MEM_RESPONDER_ERR_EN
  logic                    M_err;

  modport master (
    output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_data_ram_size, Mout_Wdata_ram,
    input  M_Rdata_ram, M_DataRdy, M_err
  );
  modport slave (
    input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_data_ram_size, Mout_Wdata_ram,
    output M_Rdata_ram, M_DataRdy, M_err
  );
`else
  modport master (
    output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_data_ram_size, Mout_Wdata_ram,
    input  M_Rdata_ram, M_DataRdy
  );
  modport slave (
    input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_data_ram_size, Mout_Wdata_ram,
    output M_Rdata_ram, M_DataRdy
  );
`endif
endinterface

// File: rtl/minimal_mem_responder.sv
// Fixed-latency byte-addressed memory slave for the accelerator's minimal memory port.
// Define MINIMAL_MEM_RESPONDER_ERR_EN to flag out-of-range and oe+we accesses on M_err.
module minimal_mem_responder #(
  parameter int          BITSIZE_addr = 32,
  parameter int          BITSIZE_data = 32,
  parameter int          BITSIZE_size = 6,
  parameter int          MEMSIZE      = 1024,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int          READ_DELAY   = 2,
  parameter int          WRITE_DELAY  = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  minimal_mem_responder_if.slave  bus
);

  localparam int LANES     = BITSIZE_data / 8;
  localparam int OFF_W     = $clog2(MEMSIZE);
  localparam int MAX_DELAY = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
  localparam int CNT_W     = $clog2(MAX_DELAY + 1);
  localparam logic [BITSIZE_addr-1:0] BASE_A = BITSIZE_addr'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [OFF_W-1:0]        off_q;
  int                      n_q;
  logic [BITSIZE_data-1:0] wdata_q;
  logic                    is_write_q;
  logic                    blocked;
  logic                    accept;
  logic [OFF_W-1:0]        off_in;
  logic                    rdy;
  logic [BITSIZE_data-1:0] rdata;
  logic [7:0]              mem_q [MEMSIZE];

  function automatic int calc_n(input logic [BITSIZE_size-1:0] s);
    int n;
    n = int'(s >> 3);
    if (n > LANES) n = LANES;
    return n;
  endfunction

  assign accept = (state_q == IDLE) && (bus.Mout_oe_ram || bus.Mout_we_ram);
  assign off_in = OFF_W'(bus.Mout_addr_ram - BASE_A);

`ifdef MINIMAL_MEM_RESPONDER_ERR_EN
  logic err_q;
  logic req_err;

  // Range test is done one bit wider so addr+n cannot overflow past the top of the window.
  always_comb begin
    logic [BITSIZE_addr:0] a_ext, lo_ext, hi_ext, end_ext;
    int n;
    n       = calc_n(bus.Mout_data_ram_size);
    a_ext   = {1'b0, bus.Mout_addr_ram};
    lo_ext  = (BITSIZE_addr+1)'(BASE_ADDR);
    hi_ext  = lo_ext + (BITSIZE_addr+1)'(MEMSIZE);
    end_ext = a_ext + (BITSIZE_addr+1)'(n);
    req_err = (bus.Mout_oe_ram && bus.Mout_we_ram) ||
              ((n != 0) && ((a_ext < lo_ext) || (end_ext > hi_ext)));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      err_q <= 1'b0;
    else if (accept) err_q <= req_err;
  end

  assign blocked   = err_q;
  assign bus.M_err = (state_q == RESP) && err_q;
`else
  assign blocked = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      off_q      <= '0;
      n_q        <= 0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        off_q      <= off_in;
        n_q        <= calc_n(bus.Mout_data_ram_size);
        wdata_q    <= bus.Mout_Wdata_ram;
        is_write_q <= bus.Mout_we_ram;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = bus.Mout_we_ram ? CNT_W'(WRITE_DELAY) : CNT_W'(READ_DELAY);
          state_d = (cnt_d == CNT_W'(1)) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rdy   = 1'b0;
    rdata = '0;
    if (state_q == RESP) begin
      rdy = 1'b1;
      if (!is_write_q && !blocked) begin
        for (int i = 0; i < LANES; i++) begin
          if (i < n_q) rdata[8*i +: 8] = mem_q[off_q + OFF_W'(i)];
        end
      end
    end
  end

  assign bus.M_DataRdy   = rdy;
  assign bus.M_Rdata_ram = rdata;

  // Storage has no reset; the commit happens on the edge that leaves RESP.
  always_ff @(posedge clock) begin
    if ((state_q == RESP) && is_write_q && !blocked) begin
      for (int i = 0; i < LANES; i++) begin
        if (i < n_q) mem_q[off_q + OFF_W'(i)] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_minimal_mem_responder.sv
// Directed bench for minimal_mem_responder: a default instance and one with WRITE_DELAY=3.
module tb_minimal_mem_responder;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  minimal_mem_responder_if #(.BITSIZE_addr(32), .BITSIZE_data(32), .BITSIZE_size(6)) a_if ();
  minimal_mem_responder_if #(.BITSIZE_addr(32), .BITSIZE_data(32), .BITSIZE_size(6)) b_if ();

  minimal_mem_responder u_dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (a_if.slave)
  );

  minimal_mem_responder #(.WRITE_DELAY(3)) u_dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (b_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic drive(input int sel, input logic oe, input logic we, input logic [31:0] addr,
                       input logic [5:0] size, input logic [31:0] wdata);
    if (sel == 0) begin
      a_if.Mout_oe_ram = oe; a_if.Mout_we_ram = we; a_if.Mout_addr_ram = addr;
      a_if.Mout_data_ram_size = size; a_if.Mout_Wdata_ram = wdata;
    end else begin
      b_if.Mout_oe_ram = oe; b_if.Mout_we_ram = we; b_if.Mout_addr_ram = addr;
      b_if.Mout_data_ram_size = size; b_if.Mout_Wdata_ram = wdata;
    end
  endtask

  function automatic logic get_rdy(input int sel);
    return (sel == 0) ? a_if.M_DataRdy : b_if.M_DataRdy;
  endfunction

  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? a_if.M_Rdata_ram : b_if.M_Rdata_ram;
  endfunction

  function automatic logic get_err(input int sel);
`ifdef MINIMAL_MEM_RESPONDER_ERR_EN
    return (sel == 0) ? a_if.M_err : b_if.M_err;
`else
    return (sel == 0) ? 1'b0 : 1'b0;
`endif
  endfunction

  // Called #1 after a rising edge; the request is accepted at the next edge, held
  // through the DataRdy cycle, dropped in the following IDLE cycle, then watched.
  task automatic applyStimulus(input int sel, input logic oe, input logic we, input logic [31:0] addr,
                               input logic [5:0] size, input logic [31:0] wdata,
                               output logic [31:0] rdata, output int lat, output logic err,
                               output logic [31:0] idle_rd, output int extra);
    lat = -1; rdata = '0; err = 1'b0; idle_rd = '0; extra = 0;
    drive(sel, oe, we, addr, size, wdata);
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(posedge clock); #1;
      if (get_rdy(sel)) begin
        lat = k; rdata = get_rdata(sel); err = get_err(sel);
      end else begin
        idle_rd = idle_rd | get_rdata(sel);
      end
    end
    @(posedge clock); #1;
    drive(sel, 1'b0, 1'b0, 32'h0, 6'd0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      if (get_rdy(sel)) extra++;
    end
  endtask

  task automatic do_write(input int sel, input logic [31:0] addr, input logic [5:0] size,
                          input logic [31:0] wdata, input int exp_lat, input string tag);
    logic [31:0] rd, idle_rd;
    int lat, extra;
    logic err;
    applyStimulus(sel, 1'b0, 1'b1, addr, size, wdata, rd, lat, err, idle_rd, extra);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_extra"}, 32'(extra), 32'd0);
`ifdef MINIMAL_MEM_RESPONDER_ERR_EN
    checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
`endif
  endtask

  task automatic do_read(input int sel, input logic [31:0] addr, input logic [5:0] size,
                         input logic [31:0] exp_data, input string tag);
    logic [31:0] rd, idle_rd;
    int lat, extra;
    logic err;
    applyStimulus(sel, 1'b1, 1'b0, addr, size, 32'h0, rd, lat, err, idle_rd, extra);
    checkOutput({tag, "_data"}, rd, exp_data);
    checkOutput({tag, "_lat"}, 32'(lat), 32'd2);
    checkOutput({tag, "_idle_rdata"}, idle_rd, 32'd0);
  endtask

  initial begin
    logic [31:0] rd, idle_rd;
    int lat, extra;
    logic err;
    checks = 0;
    errors = 0;
    drive(0, 1'b0, 1'b0, 32'h0, 6'd0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 6'd0, 32'h0);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_rdy_a", {31'd0, a_if.M_DataRdy}, 32'd0);
    checkOutput("reset_rdata_a", a_if.M_Rdata_ram, 32'd0);
    checkOutput("reset_rdy_b", {31'd0, b_if.M_DataRdy}, 32'd0);
`ifdef MINIMAL_MEM_RESPONDER_ERR_EN
    checkOutput("reset_err_a", {31'd0, a_if.M_err}, 32'd0);
`endif
    reset = 1'b1;
    @(posedge clock); #1;

    do_write(0, 32'h10, 6'd32, 32'hDEADBEEF, 1, "wr32");
    do_read (0, 32'h10, 6'd32, 32'hDEADBEEF, "rd32");
    do_write(0, 32'h12, 6'd8, 32'h000000AA, 1, "wr8");
    do_read (0, 32'h10, 6'd32, 32'hDEAABEEF, "rd32_after_wr8");
    do_read (0, 32'h12, 6'd16, 32'h0000DEAA, "rd16");
    do_read (0, 32'h13, 6'd8, 32'h000000DE, "rd8");
    do_read (0, 32'h10, 6'd40, 32'hDEAABEEF, "rd_size_clamp");

    do_write(0, 32'h10, 6'd0, 32'hFFFFFFFF, 1, "wr_size0");
    do_read (0, 32'h10, 6'd32, 32'hDEAABEEF, "rd_after_size0");
    do_read (0, 32'h10, 6'd0, 32'h00000000, "rd_size0");

    do_write(0, 32'h30, 6'd32, 32'h12345678, 1, "wr30");
    applyStimulus(0, 1'b1, 1'b1, 32'h30, 6'd32, 32'hCAFEF00D, rd, lat, err, idle_rd, extra);
    checkOutput("both_lat", 32'(lat), 32'd1);
    checkOutput("both_extra", 32'(extra), 32'd0);
`ifdef MINIMAL_MEM_RESPONDER_ERR_EN
    checkOutput("both_err", {31'd0, err}, 32'd1);
    do_read(0, 32'h30, 6'd32, 32'h12345678, "rd_after_both");

    do_write(0, 32'h0, 6'd8, 32'h00000055, 1, "wr0");
    applyStimulus(0, 1'b0, 1'b1, 32'd1024, 6'd8, 32'h00000099, rd, lat, err, idle_rd, extra);
    checkOutput("oor_lat", 32'(lat), 32'd1);
    checkOutput("oor_err", {31'd0, err}, 32'd1);
    applyStimulus(0, 1'b0, 1'b1, 32'd1022, 6'd32, 32'hA1B2C3D4, rd, lat, err, idle_rd, extra);
    checkOutput("straddle_err", {31'd0, err}, 32'd1);
    applyStimulus(0, 1'b1, 1'b0, 32'd1024, 6'd8, 32'h0, rd, lat, err, idle_rd, extra);
    checkOutput("oor_rd_err", {31'd0, err}, 32'd1);
    checkOutput("oor_rd_data", rd, 32'd0);
    do_read(0, 32'h0, 6'd8, 32'h00000055, "rd0_unchanged");
`else
    do_read(0, 32'h30, 6'd32, 32'hCAFEF00D, "rd_after_both");

    do_write(0, 32'd1022, 6'd32, 32'hA1B2C3D4, 1, "wr_wrap");
    do_read (0, 32'd1022, 6'd8, 32'h000000D4, "wrap_b0");
    do_read (0, 32'd1023, 6'd8, 32'h000000C3, "wrap_b1");
    do_read (0, 32'd0, 6'd8, 32'h000000B2, "wrap_b2");
    do_read (0, 32'd1, 6'd8, 32'h000000A1, "wrap_b3");
    do_read (0, 32'd1022, 6'd32, 32'hA1B2C3D4, "wrap_rd32");
`endif

    // Reset in the DataRdy cycle of a read must clear the outputs at once.
    drive(0, 1'b1, 1'b0, 32'h10, 6'd32, 32'h0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    checkOutput("pre_reset_rdy", {31'd0, a_if.M_DataRdy}, 32'd1);
    checkOutput("pre_reset_rdata", a_if.M_Rdata_ram, 32'hDEAABEEF);
    reset = 1'b0;
    #1;
    checkOutput("async_reset_rdy", {31'd0, a_if.M_DataRdy}, 32'd0);
    checkOutput("async_reset_rdata", a_if.M_Rdata_ram, 32'd0);
    drive(0, 1'b0, 1'b0, 32'h0, 6'd0, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // A write interrupted by reset during WAIT must leave memory untouched.
    do_write(1, 32'h40, 6'd32, 32'h01020304, 3, "b_wr");
    do_read (1, 32'h40, 6'd32, 32'h01020304, "b_rd");
    drive(1, 1'b0, 1'b1, 32'h40, 6'd32, 32'hFFFFFFFF);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    checkOutput("b_reset_rdy", {31'd0, b_if.M_DataRdy}, 32'd0);
    checkOutput("b_reset_rdata", b_if.M_Rdata_ram, 32'd0);
    drive(1, 1'b0, 1'b0, 32'h0, 6'd0, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    do_read(1, 32'h40, 6'd32, 32'h01020304, "b_rd_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
